// File: rtl/alu_cmd_driver_if.sv
// Operand/result bundle between the ALU command driver (master) and the
// combinational ALU (slave).
interface alu_cmd_driver_if #(
    parameter int N = 4
);
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [1:0]   alu_op;
    logic [N-1:0] alu_result;
    logic         alu_n;
    logic         alu_z;
    logic         alu_c;
    logic         alu_v;

    modport master (
        output alu_a, alu_b, alu_op,
        input  alu_result, alu_n, alu_z, alu_c, alu_v
    );

    modport slave (
        input  alu_a, alu_b, alu_op,
        output alu_result, alu_n, alu_z, alu_c, alu_v
    );
endinterface

// File: rtl/alu_cmd_driver.sv
// Switch-driven front end for the combinational ALU: latch operands, execute,
// settle, capture result and NZCV. Optional result checker: ALU_CMD_CHECK_EN.
module alu_cmd_driver #(
    parameter int N      = 4,
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          sw_data,
    input  logic [1:0]            sw_op,
    input  logic                  load_a,
    input  logic                  load_b,
    input  logic                  exec,
    alu_cmd_driver_if.master      alu,
    output logic [N-1:0]          res_q,
    output logic [3:0]            flags_q,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            op_count,
    output logic                  mismatch,
    output logic [1:0]            fsm_state
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] cnt;

    assign busy      = (state != ST_IDLE);
    assign fsm_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            alu.alu_a <= '0;
            alu.alu_b <= '0;
            alu.alu_op <= 2'b00;
            res_q     <= '0;
            flags_q   <= 4'd0;
            done      <= 1'b0;
            op_count  <= 8'd0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Loads land on the same edge as exec, so exec sees new operands.
                    if (load_a) alu.alu_a <= sw_data;
                    if (load_b) alu.alu_b <= sw_data;
                    if (exec) begin
                        alu.alu_op <= sw_op;
                        cnt        <= 4'(SETTLE - 1);
                        state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) state <= ST_CAPTURE;
                    else             cnt   <= cnt - 4'd1;
                end
                ST_CAPTURE: begin
                    res_q    <= alu.alu_result;
                    flags_q  <= {alu.alu_n, alu.alu_z, alu.alu_c, alu.alu_v};
                    op_count <= op_count + 8'd1;
                    done     <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ALU_CMD_CHECK_EN
    logic [N-1:0] exp_res;

    always_comb begin
        exp_res = '0;
        case (alu.alu_op)
            2'b00:   exp_res = alu.alu_a + alu.alu_b;
            2'b01:   exp_res = alu.alu_a - alu.alu_b;
            2'b10:   exp_res = alu.alu_a & alu.alu_b;
            default: exp_res = alu.alu_a | alu.alu_b;
        endcase
    end

    // Carry and overflow conventions vary between ALUs, so only N and Z are judged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch <= 1'b0;
        end else if (state == ST_CAPTURE) begin
            if ((exp_res != alu.alu_result) ||
                (exp_res[N-1] != alu.alu_n) ||
                ((exp_res == '0) != alu.alu_z))
                mismatch <= 1'b1;
        end
    end
`else
    assign mismatch = 1'b0;
`endif
endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver: one instance with SETTLE=1, one with SETTLE=4.
module tb_alu_cmd_driver;
    logic       clk;
    logic       rst;
    logic [3:0] sw_data;
    logic [1:0] sw_op;
    logic       load_a, load_b;
    logic       exec1, exec4;
    bit         bad;

    logic [3:0] res1, res4;
    logic [3:0] flg1, flg4;
    logic       busy1, busy4, done1, done4, mis1, mis4;
    logic [7:0] cnt1, cnt4;
    logic [1:0] st1, st4;

    int checks = 0;
    int errors = 0;

    alu_cmd_driver_if #(.N(4)) bus1 ();
    alu_cmd_driver_if #(.N(4)) bus4 ();

    alu_cmd_driver #(.N(4), .SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .sw_data(sw_data), .sw_op(sw_op),
        .load_a(load_a), .load_b(load_b), .exec(exec1), .alu(bus1.master),
        .res_q(res1), .flags_q(flg1), .busy(busy1), .done(done1),
        .op_count(cnt1), .mismatch(mis1), .fsm_state(st1)
    );

    alu_cmd_driver #(.N(4), .SETTLE(4)) dut4 (
        .clk(clk), .rst(rst), .sw_data(sw_data), .sw_op(sw_op),
        .load_a(load_a), .load_b(load_b), .exec(exec4), .alu(bus4.master),
        .res_q(res4), .flags_q(flg4), .busy(busy4), .done(done4),
        .op_count(cnt4), .mismatch(mis4), .fsm_state(st4)
    );

    // Behavioural ALU; 'bad' makes AND behave as OR to exercise the checker.
    function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] op, input bit fault);
        logic [4:0] s;
        logic [3:0] r;
        logic       c, v;
        s = 5'd0; r = 4'd0; c = 1'b0; v = 1'b0;
        case (op)
            2'b00: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[3:0]; c = s[4];
                v = (a[3] == b[3]) && (r[3] != a[3]);
            end
            2'b01: begin
                r = a - b; c = (a >= b);
                v = (a[3] != b[3]) && (r[3] != a[3]);
            end
            2'b10: r = fault ? (a | b) : (a & b);
            default: r = a | b;
        endcase
        return {r[3], (r == 4'd0), c, v, r};
    endfunction

    assign {bus1.alu_n, bus1.alu_z, bus1.alu_c, bus1.alu_v, bus1.alu_result} =
        alu_f(bus1.alu_a, bus1.alu_b, bus1.alu_op, bad);
    assign {bus4.alu_n, bus4.alu_z, bus4.alu_c, bus4.alu_v, bus4.alu_result} =
        alu_f(bus4.alu_a, bus4.alu_b, bus4.alu_op, bad);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic load_ab(input logic [3:0] a, input logic [3:0] b);
        sw_data = a; load_a = 1'b1; step(); load_a = 1'b0;
        sw_data = b; load_b = 1'b1; step(); load_b = 1'b0;
    endtask

    // Launch one operation and measure exec->done latency and busy cycles.
    task automatic exec_op(input bit sel, input logic [3:0] a, input logic [3:0] b,
                           input logic [1:0] op, output int lat, output int bc);
        bit found, both;
        load_ab(a, b);
        sw_op = op;
        if (sel) exec4 = 1'b1; else exec1 = 1'b1;
        step();
        exec1 = 1'b0; exec4 = 1'b0;
        lat = 0; bc = 0; found = 1'b0; both = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (sel ? busy4 : busy1) bc++;
            if ((sel ? busy4 : busy1) && (sel ? done4 : done1)) both = 1'b1;
            if (sel ? done4 : done1) begin
                found = 1'b1;
                break;
            end
            step();
            lat++;
        end
        check("done_seen", 32'(found), 32'd1);
        check("done_busy_overlap", 32'(both), 32'd0);
    endtask

    initial begin
        int lat, bc, pulses, steps;
        bit ok;
        rst = 1'b1; sw_data = 4'd0; sw_op = 2'b00;
        load_a = 1'b0; load_b = 1'b0; exec1 = 1'b0; exec4 = 1'b0; bad = 1'b0;
        step(); step();
        check("rst_res", 32'(res1), 32'd0);
        check("rst_flags", 32'(flg1), 32'd0);
        check("rst_count", 32'(cnt1), 32'd0);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_done", 32'(done1), 32'd0);
        check("rst_mismatch", 32'(mis1), 32'd0);
        check("rst_state", 32'(st1), 32'd0);
        rst = 1'b0;
        step();

        // Simultaneous loads put sw_data on both operands.
        sw_data = 4'd7; load_a = 1'b1; load_b = 1'b1; step();
        load_a = 1'b0; load_b = 1'b0;
        check("dual_load_a", 32'(bus1.alu_a), 32'd7);
        check("dual_load_b", 32'(bus1.alu_b), 32'd7);

        // Reset while waiting aborts the operation.
        load_ab(4'd3, 4'd5);
        sw_op = 2'b00; exec1 = 1'b1; step(); exec1 = 1'b0;
        check("abort_busy", 32'(busy1), 32'd1);
        #3 rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin step(); if (done1) pulses++; end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin step(); if (done1) pulses++; end
        check("abort_no_done", 32'(pulses), 32'd0);
        check("abort_res", 32'(res1), 32'd0);
        check("abort_flags", 32'(flg1), 32'd0);
        check("abort_count", 32'(cnt1), 32'd0);
        check("abort_busy_low", 32'(busy1), 32'd0);
        check("abort_alu_a", 32'(bus1.alu_a), 32'd0);

        // 3 + 5 = 8: N=1 Z=0 C=0 V=1
        exec_op(1'b0, 4'd3, 4'd5, 2'b00, lat, bc);
        check("add_latency", 32'(lat), 32'd2);
        check("add_busy_cycles", 32'(bc), 32'd2);
        check("add_res", 32'(res1), 32'h8);
        check("add_flags", 32'(flg1), 32'b1001);
        check("add_count", 32'(cnt1), 32'd1);
        check("add_mismatch", 32'(mis1), 32'd0);

        // 5 - 5 = 0: N=0 Z=1 C=1 (no borrow) V=0
        exec_op(1'b0, 4'd5, 4'd5, 2'b01, lat, bc);
        check("sub_res", 32'(res1), 32'd0);
        check("sub_z", 32'(flg1[2]), 32'd1);
        check("sub_n", 32'(flg1[3]), 32'd0);
        check("sub_flags", 32'(flg1), 32'b0110);
        check("sub_count", 32'(cnt1), 32'd2);

        // Strobes while busy are dropped.
        load_ab(4'd3, 4'd5);
        sw_op = 2'b00; exec1 = 1'b1; step(); exec1 = 1'b0;
        sw_data = 4'hF; sw_op = 2'b11; load_a = 1'b1; exec1 = 1'b1; step();
        load_a = 1'b0; exec1 = 1'b0;
        check("ign_alu_a", 32'(bus1.alu_a), 32'd3);
        check("ign_alu_op", 32'(bus1.alu_op), 32'd0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin if (done1) pulses++; step(); end
        check("ign_one_done", 32'(pulses), 32'd1);
        check("ign_res", 32'(res1), 32'h8);
        check("ign_count", 32'(cnt1), 32'd3);
        check("ign_alu_a_after", 32'(bus1.alu_a), 32'd3);

        // SETTLE=4: done after edge k+5, busy for 5 cycles.
        exec_op(1'b1, 4'd9, 4'd2, 2'b11, lat, bc);
        check("s4_latency", 32'(lat), 32'd5);
        check("s4_busy_cycles", 32'(bc), 32'd5);
        check("s4_res", 32'(res4), 32'hB);
        check("s4_flags", 32'(flg4), 32'b1000);

        // 256 back-to-back ANDs from a fresh reset wrap op_count to 0.
        rst = 1'b1; step(); rst = 1'b0; step();
        load_ab(4'hC, 4'hA);
        sw_op = 2'b10; exec4 = 1'b1; steps = 0; ok = 1'b1;
        for (int n = 0; n < 256; n++) begin
            step(); steps++; exec4 = 1'b0;
            begin : wait_done
                for (int i = 0; i < 20; i++) begin
                    if (done4) disable wait_done;
                    step(); steps++;
                end
                ok = 1'b0;
            end
            if (n == 254) check("wrap_count_255", 32'(cnt4), 32'd255);
            exec4 = (n < 255);
        end
        check("wrap_done_seen", 32'(ok), 32'd1);
        check("wrap_steps", 32'(steps), 32'd1536);
        check("wrap_count", 32'(cnt4), 32'd0);
        check("wrap_res", 32'(res4), 32'h8);
        check("wrap_flags", 32'(flg4), 32'b1000);
        check("wrap_busy", 32'(busy4), 32'd0);

        // Faulty ALU on AND: C & A should be 8, faulty ALU returns E.
        bad = 1'b1;
        exec_op(1'b0, 4'hC, 4'hA, 2'b10, lat, bc);
        bad = 1'b0;
        check("bad_res", 32'(res1), 32'hE);
`ifdef ALU_CMD_CHECK_EN
        check("mismatch_set", 32'(mis1), 32'd1);
`else
        check("mismatch_off", 32'(mis1), 32'd0);
`endif
        exec_op(1'b0, 4'd1, 4'd1, 2'b00, lat, bc);
        check("good_res_after", 32'(res1), 32'd2);
`ifdef ALU_CMD_CHECK_EN
        check("mismatch_sticky", 32'(mis1), 32'd1);
`else
        check("mismatch_off_2", 32'(mis1), 32'd0);
`endif
        rst = 1'b1; step(); rst = 1'b0; step();
        check("mismatch_cleared", 32'(mis1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_cmd_driver.md
# alu_cmd_driver

Sequential front end that drives the combinational ALU. It latches two operands and an operation code from board switches under strobe control. On an execute strobe it presents them to the ALU, waits a programmable settle time, then registers the ALU result and NZCV flags for the display and status logic. It sits between the switch/button inputs and the ALU, and is the initiator side of the ALU's operand/result interface.

## Interface

- N, default 4, operand/result width; legal range 2–16.
- SETTLE, default 1, number of wait cycles before capture; legal range 1–15.

- clk, in, 1, system clock; all state updates on its rising edge.
- rst, in, 1, asynchronous active-high reset.
- sw_data, in, N, operand value from switches.
- sw_op, in, 2, operation select: 00 add, 01 sub, 10 AND, 11 OR.
- load_a, in, 1, single-cycle strobe: alu_a <= sw_data.
- load_b, in, 1, single-cycle strobe: alu_b <= sw_data.
- exec, in, 1, single-cycle strobe: alu_op <= sw_op and start an operation.
- alu_a, out, N, registered operand A to the ALU.
- alu_b, out, N, registered operand B to the ALU.
- alu_op, out, 2, registered operation code to the ALU.
- alu_result, in, N, ALU result.
- alu_n, alu_z, alu_c, alu_v, in, 1 each, ALU status flags.
- res_q, out, N, captured result.
- flags_q, out, 4, captured flags {N,Z,C,V} (bit 3 = N).
- busy, out, 1, high while the FSM is not in IDLE.
- done, out, 1, one-cycle pulse on the cycle after capture.
- op_count, out, 8, count of completed operations; wraps 255 -> 0.
- mismatch, out, 1, sticky checker error (see Configuration).

## Operation

- FSM states: IDLE, WAIT, CAPTURE.
- IDLE:
  - load_a / load_b are accepted; both may be asserted together, and both operands then take sw_data.
  - exec: alu_op <= sw_op, wait counter <= SETTLE-1, next state WAIT.
  - A load and exec on the same edge: the load updates the operand on that edge, so the operation uses the new value.
- WAIT: if counter == 0, go to CAPTURE; otherwise decrement the counter.
- CAPTURE: on the exit edge, res_q <= alu_result, flags_q <= {alu_n,alu_z,alu_c,alu_v}, op_count += 1 (mod 256), done <= 1; next state IDLE.
- While busy, load_a, load_b and exec are ignored, not queued. alu_a, alu_b and alu_op are held stable from exec acceptance until IDLE.
- res_q and flags_q hold their value until the next capture.
- Reset, asynchronous and at any time including mid-operation:
  - state IDLE, outputs and all registers 0, including op_count and mismatch.
  - An aborted operation produces no done pulse and no capture.

## Timing

- exec sampled on edge k, with SETTLE = S:
  - edges k+1 .. k+S: WAIT; the transition to CAPTURE occurs on edge k+S.
  - edge k+S+1: capture.
  - done is high for exactly the cycle following edge k+S+1.
- busy is high from edge k to edge k+S+1, i.e. S+1 cycles.
- done and busy are never high in the same cycle.
- exec asserted during the done cycle is accepted, giving back-to-back operations with one IDLE cycle between them.
- The ALU is purely combinational. SETTLE covers board-level timing margin only; there are no functional pipeline stages.

## Configuration

- Macro: ALU_CMD_CHECK_EN.
- Defined:
  - An internal reference model computes the expected result from alu_a, alu_b and alu_op in the CAPTURE state: (a+b), (a-b), a&b or a|b, each mod 2^N.
  - The model also derives the expected N (MSB) and Z (result == 0).
  - Any difference from alu_result, alu_n or alu_z at capture sets mismatch = 1, sticky until rst.
  - C and V are not checked.
- Undefined: no checker logic; mismatch is tied to 0.

## Test plan

- Reset mid-WAIT (S=1, N=4; load A=3, B=5, exec with sw_op=00, assert rst at edge k+1) -> no done pulse; res_q=0, flags_q=0, op_count=0, busy=0.
- Add (N=4, S=1; A=3, B=5, sw_op=00) -> done on the cycle after edge k+2; res_q=4'h8, flags_q N=1, Z=0, V=1; op_count=1.
- Sub to zero (A=5, B=5, sw_op=01) -> res_q=0, flags_q Z=1, N=0; op_count increments.
- Ignored strobes: exec plus load_a with sw_data=F during WAIT -> alu_a unchanged, exactly one done pulse, result from the original operands.
- SETTLE=4 latency: exec at edge k -> busy high for 5 cycles, done after edge k+5. Then 256 back-to-back AND operations -> op_count wraps to 0.
- With ALU_CMD_CHECK_EN, ALU model forced to return a|b for op 10 (A=C, B=A) -> mismatch=1 after capture, held until rst. With the macro undefined -> mismatch stays 0.
